// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter_if
// Purpose  : Producer-side and broadcast-side signal bundle of the CDB arbiter.
// Revision : 1.0
// ============================================================================
interface cdb_arbiter_if #(
    parameter int NICK_W = 5,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic              iclr;
    logic              iEX_en;
    logic [NICK_W-1:0] iEX_nick;
    logic [DATA_W-1:0] iEX_dt;
    logic              iEX_ac;
    logic [ADDR_W-1:0] iEX_j_pc;
    logic              oEX_full;
    logic              iSLB_en;
    logic [NICK_W-1:0] iSLB_nick;
    logic [DATA_W-1:0] iSLB_dt;
    logic              oSLB_full;
    logic              oCDB_en;
    logic              oCDB_src;
    logic [NICK_W-1:0] oCDB_nick;
    logic [DATA_W-1:0] oCDB_dt;
    logic              oCDB_ac;
    logic [ADDR_W-1:0] oCDB_j_pc;
    logic              oOVF;

    modport master (
        output rdy, iclr,
        output iEX_en, iEX_nick, iEX_dt, iEX_ac, iEX_j_pc,
        output iSLB_en, iSLB_nick, iSLB_dt,
        input  oEX_full, oSLB_full,
        input  oCDB_en, oCDB_src, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc, oOVF
    );

    modport slave (
        input  rdy, iclr,
        input  iEX_en, iEX_nick, iEX_dt, iEX_ac, iEX_j_pc,
        input  iSLB_en, iSLB_nick, iSLB_dt,
        output oEX_full, oSLB_full,
        output oCDB_en, oCDB_src, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc, oOVF
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Two-FIFO round-robin arbiter serialising EX and SLB results
//            onto one registered common data bus broadcast.
// Revision : 1.0
// ============================================================================
module cdb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int NICK_W = 5,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    cdb_arbiter_if.slave  bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_EX_W  = NICK_W + DATA_W + 1 + ADDR_W;
    localparam int c_SLB_W = NICK_W + DATA_W;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [c_EX_W-1:0]  r_ex_mem  [DEPTH];
    logic [c_SLB_W-1:0] r_slb_mem [DEPTH];
    logic [c_PTR_W-1:0] r_ex_wp, r_ex_rp, r_slb_wp, r_slb_rp;
    logic [c_CNT_W-1:0] r_ex_cnt, r_slb_cnt;
    logic               r_last_slb;

    logic               r_en, r_src, r_ac, r_ovf;
    logic [NICK_W-1:0]  r_nick;
    logic [DATA_W-1:0]  r_dt;
    logic [ADDR_W-1:0]  r_j_pc;

    logic               w_act, w_ex_full, w_slb_full, w_ex_ne, w_slb_ne;
    logic               w_gnt_ex, w_gnt_slb;
    logic               w_ex_push, w_ex_pop, w_slb_push, w_slb_pop;
    logic [c_EX_W-1:0]  w_ex_head;
    logic [c_SLB_W-1:0] w_slb_head;

    assign w_act      = bus.rdy && !bus.iclr;
    assign w_ex_full  = (r_ex_cnt == c_FULL);
    assign w_slb_full = (r_slb_cnt == c_FULL);
    assign w_ex_ne    = (r_ex_cnt != '0);
    assign w_slb_ne   = (r_slb_cnt != '0);
    assign w_ex_head  = r_ex_mem[r_ex_rp];
    assign w_slb_head = r_slb_mem[r_slb_rp];

    // On a tie the source that did not win last time is served.
    always_comb begin
        w_gnt_ex  = 1'b0;
        w_gnt_slb = 1'b0;
        if (w_ex_ne && w_slb_ne) begin
            w_gnt_ex  = r_last_slb;
            w_gnt_slb = !r_last_slb;
        end else begin
            w_gnt_ex  = w_ex_ne;
            w_gnt_slb = w_slb_ne;
        end
    end

    assign w_ex_pop   = w_act && w_gnt_ex;
    assign w_slb_pop  = w_act && w_gnt_slb;
    assign w_ex_push  = w_act && bus.iEX_en && !w_ex_full;
    assign w_slb_push = w_act && bus.iSLB_en && !w_slb_full;

    always_ff @(posedge clk) begin
        if (w_ex_push)
            r_ex_mem[r_ex_wp] <= {bus.iEX_nick, bus.iEX_dt, bus.iEX_ac, bus.iEX_j_pc};
        if (w_slb_push)
            r_slb_mem[r_slb_wp] <= {bus.iSLB_nick, bus.iSLB_dt};
    end

    always_ff @(posedge clk) begin
        if (rst || bus.iclr) begin
            r_ex_wp    <= '0;
            r_ex_rp    <= '0;
            r_slb_wp   <= '0;
            r_slb_rp   <= '0;
            r_ex_cnt   <= '0;
            r_slb_cnt  <= '0;
            r_last_slb <= 1'b1;
        end else begin
            if (w_ex_push)  r_ex_wp  <= r_ex_wp + 1'b1;
            if (w_ex_pop)   r_ex_rp  <= r_ex_rp + 1'b1;
            if (w_slb_push) r_slb_wp <= r_slb_wp + 1'b1;
            if (w_slb_pop)  r_slb_rp <= r_slb_rp + 1'b1;
            r_ex_cnt  <= r_ex_cnt + {{(c_CNT_W-1){1'b0}}, w_ex_push}
                                  - {{(c_CNT_W-1){1'b0}}, w_ex_pop};
            r_slb_cnt <= r_slb_cnt + {{(c_CNT_W-1){1'b0}}, w_slb_push}
                                   - {{(c_CNT_W-1){1'b0}}, w_slb_pop};
            if (w_ex_pop)
                r_last_slb <= 1'b0;
            else if (w_slb_pop)
                r_last_slb <= 1'b1;
        end
    end

    // Broadcast registers: cleared by reset and flush, held when idle.
    always_ff @(posedge clk) begin
        if (rst || bus.iclr) begin
            r_en   <= 1'b0;
            r_src  <= 1'b0;
            r_nick <= '0;
            r_dt   <= '0;
            r_ac   <= 1'b0;
            r_j_pc <= '0;
        end else begin
            r_en <= w_ex_pop || w_slb_pop;
            if (w_ex_pop) begin
                r_src                         <= 1'b0;
                {r_nick, r_dt, r_ac, r_j_pc}  <= w_ex_head;
            end else if (w_slb_pop) begin
                r_src          <= 1'b1;
                {r_nick, r_dt} <= w_slb_head;
                r_ac           <= 1'b0;
                r_j_pc         <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (w_act && ((bus.iEX_en && w_ex_full) || (bus.iSLB_en && w_slb_full)))
            r_ovf <= 1'b1;
    end

    assign bus.oEX_full  = w_ex_full;
    assign bus.oSLB_full = w_slb_full;
    assign bus.oCDB_en   = r_en;
    assign bus.oCDB_src  = r_src;
    assign bus.oCDB_nick = r_nick;
    assign bus.oCDB_dt   = r_dt;
    assign bus.oCDB_ac   = r_ac;
    assign bus.oCDB_j_pc = r_j_pc;
    assign bus.oOVF      = r_ovf;
endmodule
`default_nettype wire
